cpu_cycle_controller: RTL
=========================

# cpu_cycle_controller

Multi-cycle sequencer for the 16-bit CPU core. It fetches an instruction, holds it in the instruction register that feeds the instruction decoder, then steps the register file, ALU and write-back port through fixed phases. It gates the decoder's write-back and show flags into single-cycle strobes. The block sits between instruction memory, the instruction register/decoder and the register file/ALU datapath, and keeps the PC, a retired-instruction counter and a sticky fetch-timeout fault.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum cycles spent in FETCH without i_IMemValid before faulting (1..255).
- PC_WIDTH, 8: program counter width.

Ports:
- i_CLK  in  1  single clock; all state updates on rising edge.
- i_RST  in  1  reset, synchronous, active-high.
- i_Run  in  1  level; enables starting new instructions.
- i_Step  in  1  single-step request; present only with SINGLE_STEP_EN.
- o_IMemReq  out  1  instruction fetch request (level).
- o_PC  out  PC_WIDTH  fetch address.
- i_IMemValid  in  1  instruction word valid this cycle.
- o_IRLoad  out  1  load instruction register (1-cycle strobe).
- i_WriteBack  in  1  decoder write-back flag.
- i_ShowR1, i_ShowR2  in  1 each  decoder show flags.
- o_RegRead  out  1  register-file read phase.
- o_ALUEn  out  1  ALU execute phase.
- o_RegWrite  out  1  register-file write strobe.
- o_ShowLoad  out  1  display latch strobe.
- o_State  out  3  current state encoding.
- o_Fault  out  1  sticky fetch-timeout fault.
- o_InstrCount  out  16  retired instructions.

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, FAULT=7. Codes 5 and 6 are unused and go to IDLE.
- IDLE: go to FETCH when i_Run=1. The wait counter clears on entry to FETCH.
- FETCH: o_IMemReq=1. If i_IMemValid=1, o_IRLoad=1 in the same cycle and the next state is DECODE. Otherwise the wait counter increments. When the counter equals MEM_TIMEOUT-1 and valid is still low, the next state is FAULT. If valid and timeout occur in the same cycle, valid wins.
- DECODE: o_RegRead=1 for 1 cycle, then EXEC.
- EXEC: o_ALUEn=1 for 1 cycle, then WB.
- WB: o_RegWrite=i_WriteBack and o_ShowLoad=i_ShowR1|i_ShowR2. At the closing edge, o_PC and o_InstrCount each increment by 1 and wrap modulo 2^width. Next state is FETCH if i_Run=1, otherwise IDLE.
- FAULT: o_Fault=1. Only i_RST exits this state.
- i_Run deasserted mid-instruction: the current instruction completes through WB, then the controller enters IDLE.
- Strobes (o_IMemReq, o_IRLoad, o_RegRead, o_ALUEn, o_RegWrite, o_ShowLoad) decode combinationally from state and are forced to 0 while i_RST=1.

## Timing
- Reset values: state IDLE, o_PC=0, o_InstrCount=0, o_Fault=0, wait counter 0, all strobes 0.
- Reset mid-operation takes effect at the next edge from any state. No o_RegWrite pulse occurs during the reset cycle.
- Minimum instruction latency is 4 cycles (FETCH, DECODE, EXEC, WB) when valid arrives in the first FETCH cycle. Each additional FETCH wait cycle adds 1 cycle.
- Back-to-back throughput with i_Run held high is 1 instruction per 4 cycles.
- Decoder outputs are sampled only in WB. The instruction register is stable from DECODE through WB.
- o_PC changes only at the WB closing edge, so the address is stable for the whole of FETCH.

## Configuration
- SINGLE_STEP_EN defined:
  - i_Step port exists.
  - IDLE→FETCH requires i_Run=1 and i_Step=1.
  - WB always returns to IDLE, so exactly one instruction runs per step.
- Undefined:
  - No i_Step port.
  - Free-running operation as described above.

## Test plan
- Reset, i_Run=1, valid on first FETCH cycle, i_WriteBack=1 → states 1,2,3,4,1; o_RegWrite high for exactly one cycle (cycle 4); o_PC 0→1; o_InstrCount 0→1.
- i_WriteBack=0, i_ShowR1=1 during WB → o_RegWrite stays 0; o_ShowLoad pulses once.
- MEM_TIMEOUT=15, valid held low → FAULT after 15 FETCH cycles; o_Fault=1 until i_RST. A variant with valid on the 15th cycle → DECODE, no fault.
- o_PC=255 (PC_WIDTH=8) and o_InstrCount=16'hFFFF, retire one instruction → both wrap to 0.
- Drop i_Run during EXEC → WB completes, state goes to IDLE. Assert i_RST during WB → next state IDLE, no o_RegWrite pulse, counters 0.
- With SINGLE_STEP_EN, i_Run=1 and i_Step pulsed twice → exactly 2 instructions retire, returning to IDLE after each.

Source files
------------

// File: rtl/cpu_cycle_controller.sv
// rtl/cpu_cycle_controller.sv - multi-cycle FETCH/DECODE/EXEC/WB sequencer with fetch timeout fault.
// Optional single-step mode selected by defining SINGLE_STEP_EN (adds i_Step).
module cpu_cycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int PC_WIDTH    = 8
) (
  input  logic                i_CLK,
  input  logic                i_RST,
  input  logic                i_Run,
`ifdef SINGLE_STEP_EN
  input  logic                i_Step,
`endif
  output logic                o_IMemReq,
  output logic [PC_WIDTH-1:0] o_PC,
  input  logic                i_IMemValid,
  output logic                o_IRLoad,
  input  logic                i_WriteBack,
  input  logic                i_ShowR1,
  input  logic                i_ShowR2,
  output logic                o_RegRead,
  output logic                o_ALUEn,
  output logic                o_RegWrite,
  output logic                o_ShowLoad,
  output logic [2:0]          o_State,
  output logic                o_Fault,
  output logic [15:0]         o_InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_wait;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [15:0]           r_instr_count;
  logic                  w_start;
  state_t                w_after_wb;

`ifdef SINGLE_STEP_EN
  assign w_start    = i_Run & i_Step;
  assign w_after_wb = S_IDLE;
`else
  assign w_start    = i_Run;
  assign w_after_wb = i_Run ? S_FETCH : S_IDLE;
`endif

  always_comb begin
    w_next     = S_IDLE;
    o_IMemReq  = 1'b0;
    o_IRLoad   = 1'b0;
    o_RegRead  = 1'b0;
    o_ALUEn    = 1'b0;
    o_RegWrite = 1'b0;
    o_ShowLoad = 1'b0;
    case (r_state)
      S_IDLE:   w_next = w_start ? S_FETCH : S_IDLE;
      S_FETCH: begin
        o_IMemReq = 1'b1;
        // A valid word arriving on the last allowed cycle still wins over the timeout.
        if (i_IMemValid) begin
          o_IRLoad = 1'b1;
          w_next   = S_DECODE;
        end else if (r_wait == LP_WAIT_LAST) begin
          w_next = S_FAULT;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        o_RegRead = 1'b1;
        w_next    = S_EXEC;
      end
      S_EXEC: begin
        o_ALUEn = 1'b1;
        w_next  = S_WB;
      end
      S_WB: begin
        o_RegWrite = i_WriteBack;
        o_ShowLoad = i_ShowR1 | i_ShowR2;
        w_next     = w_after_wb;
      end
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_IDLE;
    endcase
    if (i_RST) begin
      o_IMemReq  = 1'b0;
      o_IRLoad   = 1'b0;
      o_RegRead  = 1'b0;
      o_ALUEn    = 1'b0;
      o_RegWrite = 1'b0;
      o_ShowLoad = 1'b0;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state       <= S_IDLE;
      r_wait        <= 8'd0;
      r_pc          <= '0;
      r_instr_count <= 16'd0;
    end else begin
      r_state <= w_next;
      // Held at zero outside FETCH so every FETCH entry starts a fresh count.
      if (r_state != S_FETCH) begin
        r_wait <= 8'd0;
      end else if (!i_IMemValid) begin
        r_wait <= r_wait + 8'd1;
      end
      if (r_state == S_WB) begin
        r_pc          <= r_pc + 1'b1;
        r_instr_count <= r_instr_count + 16'd1;
      end
    end
  end

  assign o_PC         = r_pc;
  assign o_InstrCount = r_instr_count;
  assign o_State      = r_state;
  assign o_Fault      = (r_state == S_FAULT);

endmodule
